mem_fill_responder: RTL and testbench

- Memory-side responder for the cache fill path; the other end of the cache miss handler's read stream.
- Accepts one word request per cycle (read or write) and returns read data after a fixed pipeline latency, qualified by data_valid.
- Sits between the instruction/data cache fill FSMs and the backing word array.
- Fully pipelined: a 16-byte block fill (8 reads at offsets 0,2,...,14) completes LATENCY cycles after the last issue.

---
 rtl/mem_fill_responder_if.sv | 25 ++
 rtl/mem_fill_responder.sv | 73 +++++++
 tb/tb_mem_fill_responder.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/mem_fill_responder_if.sv
// rtl/mem_fill_responder_if.sv - request/response bus between the cache fill FSMs and the memory responder
interface mem_fill_responder_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int CNT_W  = 4
);
    logic              enable;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic [CNT_W-1:0]  outstanding;
    logic              busy;

    modport master (
        output enable, wr, addr, data_in,
        input  data_out, data_valid, outstanding, busy
    );

    modport slave (
        input  enable, wr, addr, data_in,
        output data_out, data_valid, outstanding, busy
    );
endinterface

// File: rtl/mem_fill_responder.sv
// rtl/mem_fill_responder.sv - fixed-latency pipelined word-array responder for cache fills
module mem_fill_responder #(
    parameter int    ADDR_W      = 16,
    parameter int    DATA_W      = 16,
    parameter int    DEPTH_WORDS = 512,
    parameter int    LATENCY     = 4,
    parameter int    CNT_W       = 4,
    parameter string INIT_FILE   = "loadfile_all.img"
) (
    input logic                 clk,
    input logic                 rst,
    mem_fill_responder_if.slave bus
);
    localparam int               IDX_W   = $clog2(DEPTH_WORDS);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [DATA_W-1:0] mem [DEPTH_WORDS] = '{default: '0};

    localparam string unused_init_file = INIT_FILE;

    logic [IDX_W-1:0]   word_idx;
    logic               issue;
    logic               retire;
    logic [LATENCY-1:0] stage_valid;
    logic [DATA_W-1:0]  stage_data [LATENCY];
    logic [CNT_W-1:0]   outstanding_q;
    logic [CNT_W-1:0]   outstanding_d;
    logic               unused_addr_bits;

    // addr[0] and bits above the word index are dropped, so indexes wrap
    assign word_idx         = bus.addr[IDX_W:1];
    assign unused_addr_bits = ^{bus.addr[ADDR_W-1:IDX_W+1], bus.addr[0]};
    assign issue            = bus.enable && !bus.wr;
    assign retire           = stage_valid[LATENCY-1];

    always_ff @(posedge clk) begin
        if (rst && bus.enable && bus.wr) begin
            mem[word_idx] <= bus.data_in;
        end
    end

    // Stage 0 captures the pre-edge word, so a read never sees a write from the same edge
    always_ff @(posedge clk) begin
        stage_data[0] <= mem[word_idx];
        for (int i = 1; i < LATENCY; i++) begin
            stage_data[i] <= stage_data[i-1];
        end
        if (!rst) begin
            stage_valid   <= '0;
            outstanding_q <= '0;
        end else begin
            stage_valid[0] <= issue;
            for (int i = 1; i < LATENCY; i++) begin
                stage_valid[i] <= stage_valid[i-1];
            end
            outstanding_q <= outstanding_d;
        end
    end

    always_comb begin
        outstanding_d = outstanding_q;
        if (issue && !retire && outstanding_q != CNT_MAX) begin
            outstanding_d = outstanding_q + 1'b1;
        end else if (!issue && retire && outstanding_q != '0) begin
            outstanding_d = outstanding_q - 1'b1;
        end
    end

    assign bus.data_valid  = stage_valid[LATENCY-1];
    assign bus.data_out    = stage_data[LATENCY-1] & {DATA_W{stage_valid[LATENCY-1]}};
    assign bus.outstanding = outstanding_q;
    assign bus.busy        = (outstanding_q != '0);
endmodule

// File: tb/tb_mem_fill_responder.sv
// tb/tb_mem_fill_responder.sv - directed-vector bench for mem_fill_responder at LATENCY 4 and 1
module tb_mem_fill_responder;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mem_fill_responder_if #(.ADDR_W(16), .DATA_W(16), .CNT_W(4)) b4 ();
    mem_fill_responder_if #(.ADDR_W(16), .DATA_W(16), .CNT_W(4)) b1 ();

    mem_fill_responder #(.LATENCY(4)) dut4 (.clk(clk), .rst(rst), .bus(b4));
    mem_fill_responder #(.LATENCY(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req4(input logic en, input logic w, input logic [15:0] a, input logic [15:0] d);
        b4.enable = en; b4.wr = w; b4.addr = a; b4.data_in = d;
    endtask

    task automatic req1(input logic en, input logic w, input logic [15:0] a, input logic [15:0] d);
        b1.enable = en; b1.wr = w; b1.addr = a; b1.data_in = d;
    endtask

    task automatic out4(input string tag, input logic v, input logic [15:0] d, input int o);
        check({tag, ".valid"}, 32'(b4.data_valid), 32'(v));
        check({tag, ".data"}, 32'(b4.data_out), 32'(d));
        check({tag, ".out"}, 32'(b4.outstanding), 32'(o));
        check({tag, ".busy"}, 32'(b4.busy), 32'(o != 0));
    endtask

    task automatic out1(input string tag, input logic v, input logic [15:0] d, input int o);
        check({tag, ".valid"}, 32'(b1.data_valid), 32'(v));
        check({tag, ".data"}, 32'(b1.data_out), 32'(d));
        check({tag, ".out"}, 32'(b1.outstanding), 32'(o));
        check({tag, ".busy"}, 32'(b1.busy), 32'(o != 0));
    endtask

    // Single isolated read on the LATENCY=4 responder: visible only after the fourth edge
    task automatic read_expect4(input string tag, input logic [15:0] a, input logic [15:0] exp);
        req4(1, 0, a, 16'h0);
        tick();
        req4(0, 0, 16'h0, 16'h0);
        out4({tag, ".e0"}, 0, 16'h0, 1);
        tick();
        out4({tag, ".e1"}, 0, 16'h0, 1);
        tick();
        out4({tag, ".e2"}, 0, 16'h0, 1);
        tick();
        out4({tag, ".e3"}, 1, exp, 1);
        tick();
        out4({tag, ".e4"}, 0, 16'h0, 0);
    endtask

    initial begin
        int peak;
        int issued;
        int retired;
        logic v;
        logic [15:0] d;
        logic [15:0] hz_data [7];
        logic        hz_valid [7];
        int          hz_out [7];

        rst = 1'b0;
        req4(0, 0, 16'h0, 16'h0);
        req1(0, 0, 16'h0, 16'h0);
        tick();
        tick();
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            out4("idle4", 0, 16'h0, 0);
            out1("idle1", 0, 16'h0, 0);
        end

        // Block fill: 8 writes then 8 back-to-back reads
        for (int i = 0; i < 8; i++) begin
            req4(1, 1, 16'(16'h0040 + 2 * i), 16'(16'h1000 + i));
            tick();
            out4("wr_fill", 0, 16'h0, 0);
        end
        peak = 0;
        for (int c = 0; c < 16; c++) begin
            if (c < 8) req4(1, 0, 16'(16'h0040 + 2 * c), 16'h0);
            else       req4(0, 0, 16'h0, 16'h0);
            tick();
            v       = (c >= 3) && (c <= 10);
            d       = v ? 16'(16'h1000 + c - 3) : 16'h0;
            issued  = (c + 1 < 8) ? c + 1 : 8;
            retired = (c >= 4) ? ((c - 3 < 8) ? c - 3 : 8) : 0;
            out4($sformatf("fill%0d", c), v, d, issued - retired);
            if (int'(b4.outstanding) > peak) peak = int'(b4.outstanding);
        end
        check("fill_peak", 32'(peak), 32'd4);

        // Read, then write the same word, then read it again
        req4(1, 1, 16'h0010, 16'hAAAA);
        tick();
        hz_valid = '{0, 0, 0, 1, 0, 1, 0};
        hz_data  = '{16'h0, 16'h0, 16'h0, 16'hAAAA, 16'h0, 16'hBBBB, 16'h0};
        hz_out   = '{1, 1, 2, 2, 1, 1, 0};
        for (int c = 0; c < 7; c++) begin
            case (c)
                0:       req4(1, 0, 16'h0010, 16'h0);
                1:       req4(1, 1, 16'h0010, 16'hBBBB);
                2:       req4(1, 0, 16'h0010, 16'h0);
                default: req4(0, 0, 16'h0, 16'h0);
            endcase
            tick();
            out4($sformatf("hazard%0d", c), hz_valid[c], hz_data[c], hz_out[c]);
        end

        // Odd byte address beyond the array wraps to word 0
        req4(1, 1, 16'h0401, 16'h5A5A);
        tick();
        read_expect4("wrap0", 16'h0000, 16'h5A5A);
        read_expect4("wrap400", 16'h0400, 16'h5A5A);

        // Reset with three reads in flight; the write presented during reset is ignored
        for (int c = 0; c < 3; c++) begin
            req4(1, 0, 16'(16'h0040 + 2 * c), 16'h0);
            tick();
            out4($sformatf("mid%0d", c), 0, 16'h0, c + 1);
        end
        req4(1, 1, 16'h0040, 16'hDEAD);
        rst = 1'b0;
        tick();
        out4("mid_rst", 0, 16'h0, 0);
        rst = 1'b1;
        req4(0, 0, 16'h0, 16'h0);
        for (int c = 0; c < 6; c++) begin
            tick();
            out4($sformatf("post_rst%0d", c), 0, 16'h0, 0);
        end
        read_expect4("after_rst", 16'h0040, 16'h1000);

        // LATENCY=1 responder with bubbles between reads
        req1(1, 1, 16'h0002, 16'h0001);
        tick();
        req1(1, 1, 16'h0004, 16'h0002);
        tick();
        out1("l1_wr", 0, 16'h0, 0);
        peak = 0;
        for (int k = 0; k < 8; k++) begin
            if (k % 2 == 0) req1(1, 0, (k % 4 == 0) ? 16'h0002 : 16'h0004, 16'h0);
            else            req1(0, 0, 16'h0, 16'h0);
            tick();
            v = (k % 2 == 0);
            d = v ? ((k % 4 == 0) ? 16'h0001 : 16'h0002) : 16'h0;
            out1($sformatf("l1_%0d", k), v, d, v ? 1 : 0);
            if (int'(b1.outstanding) > peak) peak = int'(b1.outstanding);
        end
        check("l1_peak", 32'(peak), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
